char_buf_ctl: RTL

Owns the 16x16 character text buffer (256 cells, 8 bit each) that feeds the font ROM address path. Two write requesters (game-logic message writer A, score/status updater B) share the single write port through a round-robin arbiter. A sequencer clears the whole screen to a fill character on reset and on command. The VGA side reads cells by char_xy/char_line and gets the 11-bit font ROM address char_code one cycle later.

---
 rtl/char_buf_pkg.sv | 22 ++
 rtl/char_buf_if.sv | 31 +++
 rtl/char_buf_rr_arb.sv | 29 ++
 rtl/char_buf_ctl.sv | 119 +++++++++++
 4 files changed

// File: rtl/char_buf_pkg.sv
// Shared types and sizes for the 16x16 character text buffer.
// Imported by the interface, the arbiter and the buffer controller.
package char_buf_pkg;

  localparam int XY_W   = 8;
  localparam int CHAR_W = 8;
  localparam int LINE_W = 4;
  localparam int CODE_W = 11;
  localparam int CELLS  = 256;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // One write into the cell array: address {x, y} and stored character.
  typedef struct packed {
    logic [XY_W-1:0]   xy;
    logic [CHAR_W-1:0] data;
  } wr_t;

endpackage

// File: rtl/char_buf_if.sv
// Requester, clear-control and display-read signals of the character buffer.
// master = requesters/display side, slave = the buffer controller.
interface char_buf_if;
  import char_buf_pkg::*;

  logic              a_req;
  logic [XY_W-1:0]   a_xy;
  logic [CHAR_W-1:0] a_char;
  logic              a_ready;
  logic              b_req;
  logic [XY_W-1:0]   b_xy;
  logic [CHAR_W-1:0] b_char;
  logic              b_ready;
  logic              clr_req;
  logic              clr_busy;
  logic              frame_tick;
  logic [XY_W-1:0]   rd_xy;
  logic [LINE_W-1:0] rd_line;
  logic [CODE_W-1:0] char_code;

  modport master (
    output a_req, a_xy, a_char, b_req, b_xy, b_char, clr_req, frame_tick, rd_xy, rd_line,
    input  a_ready, b_ready, clr_busy, char_code
  );

  modport slave (
    input  a_req, a_xy, a_char, b_req, b_xy, b_char, clr_req, frame_tick, rd_xy, rd_line,
    output a_ready, b_ready, clr_busy, char_code
  );

endinterface

// File: rtl/char_buf_rr_arb.sv
// 2-way round-robin arbiter for the single buffer write port.
// Latency: grants are combinational; last_grant updates on accepted writes only.
// Backpressure: a loser keeps requesting and wins next, since the winner becomes last_grant.
module char_buf_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic enable,
  input  logic accept,
  output logic gnt_a,
  output logic gnt_b
);

  // 1 = A won the last accepted write, 0 = B (reset value).
  logic last_a_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_a_q <= 1'b0;
    end else if (accept) begin
      last_a_q <= gnt_a;
    end
  end

  assign gnt_a = enable & req_a & (~req_b | ~last_a_q);
  assign gnt_b = enable & req_b & (~req_a |  last_a_q);

endmodule

// File: rtl/char_buf_ctl.sv
// 16x16 character buffer: clear sequencer, arbitrated writes, font ROM address read.
// Latency: char_code 1 cycle after rd_xy/rd_line (read-first); clear takes 256 cycles.
// Backpressure: requesters held off (ready=0) during clear and on a clr_req cycle.
// Optional blink attribute enabled by defining CHAR_BLINK_EN.
module char_buf_ctl
  import char_buf_pkg::*;
#(
  parameter logic [CHAR_W-1:0] CLR_CHAR = 8'h20,
  parameter int                BLINK_W  = 5
) (
  input  logic        clk,
  input  logic        rst,
  char_buf_if.slave   bus
);

  state_t            state_q, state_d;
  logic [XY_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [CHAR_W-1:0] mem [CELLS];
  logic              arb_en, gnt_a, gnt_b;
  logic              wr_en;
  wr_t               wr;
  logic [CHAR_W-1:0] rd_cell;
  logic [6:0]        glyph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (clr_cnt_q == 8'(CELLS - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (bus.clr_req) state_d = CLEAR;
      end
      default: state_d = CLEAR;
    endcase
  end

  // A clear request steals the cycle from both requesters.
  assign arb_en = (state_q == IDLE) && !bus.clr_req;

  char_buf_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_a  (bus.a_req),
    .req_b  (bus.b_req),
    .enable (arb_en),
    .accept (gnt_a | gnt_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr.xy   = clr_cnt_q;
    wr.data = CLR_CHAR;
    if (state_q == CLEAR) begin
      wr_en = 1'b1;
    end else if (gnt_a) begin
      wr_en   = 1'b1;
      wr.xy   = bus.a_xy;
      wr.data = bus.a_char;
    end else if (gnt_b) begin
      wr_en   = 1'b1;
      wr.xy   = bus.b_xy;
      wr.data = bus.b_char;
    end
  end

  assign bus.a_ready  = gnt_a;
  assign bus.b_ready  = gnt_b;
  assign bus.clr_busy = (state_q == CLEAR);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr.xy] <= wr.data;
  end

  assign rd_cell = mem[bus.rd_xy];

`ifdef CHAR_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
    end else if (bus.frame_tick) begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Blinking cells show the fill glyph during the high half of the frame cycle.
  assign glyph = (rd_cell[7] && blink_cnt[BLINK_W-1]) ? CLR_CHAR[6:0] : rd_cell[6:0];
`else
  logic unused_blink;
  localparam int unused_blink_w = BLINK_W;
  assign unused_blink = ^{bus.frame_tick, rd_cell[7]};
  assign glyph        = rd_cell[6:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.char_code <= '0;
    end else begin
      bus.char_code <= {glyph, bus.rd_line};
    end
  end

endmodule
